// File: rtl/wb_rr_arbiter_pkg.sv
// wb_arb_pkg: shared types, default sizes and helpers for the round-robin
// Wishbone arbiter.
//   arb_state_t    - arbiter FSM states (IDLE, OWN, YIELD)
//   DEF_*          - default parameter values
//   onehot_to_idx  - converts an up-to-8-bit one-hot vector to a binary index
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        YIELD = 2'd2
    } arb_state_t;

    localparam int unsigned DEF_NUM_MASTERS = 3;
    localparam int unsigned DEF_ADR_W       = 32;
    localparam int unsigned DEF_DAT_W       = 32;
    localparam int unsigned DEF_MAX_HOLD    = 16;
    localparam int unsigned DEF_TIMEOUT     = 64;

    // An all-zero input yields index 0; callers gate on the one-hot being valid.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// wb_arb_if: bundle of all per-master and slave-side Wishbone signals around
// the arbiter.
//   modport arb    - the arbiter itself
//   modport master - the requesting masters (drive m_* requests)
//   modport slave  - the shared slave (drives s_ack / s_dat_r)
// Per-master buses are packed: master i occupies [i*W +: W].
interface wb_arb_if
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int unsigned ADR_W       = DEF_ADR_W,
    parameter int unsigned DAT_W       = DEF_DAT_W
);
    localparam int unsigned SEL_W = DAT_W / 8;

    logic [NUM_MASTERS-1:0]       m_cyc;
    logic [NUM_MASTERS-1:0]       m_stb;
    logic [NUM_MASTERS-1:0]       m_we;
    logic [NUM_MASTERS*ADR_W-1:0] m_adr;
    logic [NUM_MASTERS*DAT_W-1:0] m_dat_w;
    logic [NUM_MASTERS*SEL_W-1:0] m_sel;
    logic [NUM_MASTERS-1:0]       m_ack;
    logic [NUM_MASTERS-1:0]       m_err;
    logic [DAT_W-1:0]             m_dat_r;

    logic                         s_cyc;
    logic                         s_stb;
    logic                         s_we;
    logic [ADR_W-1:0]             s_adr;
    logic [DAT_W-1:0]             s_dat_w;
    logic [SEL_W-1:0]             s_sel;
    logic                         s_ack;
    logic [DAT_W-1:0]             s_dat_r;

    logic [NUM_MASTERS-1:0]       grant;

    modport arb (
        input  m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel, s_ack, s_dat_r,
        output m_ack, m_err, m_dat_r, s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel, grant
    );

    modport master (
        output m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel,
        input  m_ack, m_err, m_dat_r, grant
    );

    modport slave (
        output s_ack, s_dat_r,
        input  s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel
    );

endinterface

// File: rtl/wb_rr_arbiter_picker.sv
// rr_priority_picker: combinational round-robin picker.
//   req   - request vector (one bit per master)
//   ptr   - index of the master with highest priority this round
//   gnt   - one-hot winner: first set bit of req searching circularly from ptr
//   valid - at least one request present
// Rotates req right by ptr, isolates the lowest set bit, rotates back.
module rr_priority_picker
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
    localparam int unsigned PTR_W      = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [PTR_W-1:0]       ptr,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic                   valid
);

    logic [2*NUM_MASTERS-1:0] req_dbl;
    logic [2*NUM_MASTERS-1:0] gnt_dbl;
    logic [NUM_MASTERS-1:0]   req_rot;
    logic [NUM_MASTERS-1:0]   gnt_rot;

    always_comb begin
        req_dbl = {req, req} >> ptr;
        req_rot = req_dbl[NUM_MASTERS-1:0];
        // x & -x keeps only the lowest set bit
        gnt_rot = req_rot & (~req_rot + NUM_MASTERS'(1));
        gnt_dbl = {gnt_rot, gnt_rot} << ptr;
        gnt     = gnt_dbl[2*NUM_MASTERS-1:NUM_MASTERS];
        valid   = |req;
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin arbiter sharing one classic Wishbone slave
// between NUM_MASTERS masters, with a bounded number of acks per grant while
// others wait.
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   bus  - wb_arb_if.arb: per-master requests/acks, slave port, grant vector
// Optional build macro WB_ARB_TIMEOUT_EN adds a no-ack watchdog that returns
// m_err to the owner after TIMEOUT stalled strobe cycles and hands the bus on.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int unsigned ADR_W       = DEF_ADR_W,
    parameter int unsigned DAT_W       = DEF_DAT_W,
    parameter int unsigned MAX_HOLD    = DEF_MAX_HOLD,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input logic clk,
    input logic rst,
    wb_arb_if.arb bus
);

    localparam int unsigned PTR_W = $clog2(NUM_MASTERS);
    localparam int unsigned SEL_W = DAT_W / 8;

    arb_state_t             state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [PTR_W-1:0]       rr_ptr_q;
    logic [7:0]             hold_cnt_q;

    logic [NUM_MASTERS-1:0] pick_gnt;
    logic                   pick_valid;
    logic [7:0]             grant_ext;
    logic [PTR_W-1:0]       owner;
    logic [PTR_W-1:0]       next_ptr;
    logic                   owning;
    logic                   own_cyc;
    logic                   own_stb;
    logic                   ack_seen;
    logic                   others_req;
    logic                   wdog_fire;

    rr_priority_picker #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_picker (
        .req  (bus.m_cyc),
        .ptr  (rr_ptr_q),
        .gnt  (pick_gnt),
        .valid(pick_valid)
    );

    always_comb begin
        grant_ext                  = '0;
        grant_ext[NUM_MASTERS-1:0] = grant_q;
        owner      = PTR_W'(onehot_to_idx(grant_ext));
        next_ptr   = (owner == PTR_W'(NUM_MASTERS - 1)) ? '0 : owner + PTR_W'(1);
        owning     = (state_q == OWN);
        own_cyc    = owning & bus.m_cyc[owner];
        own_stb    = owning & bus.m_stb[owner];
        ack_seen   = own_cyc & own_stb & bus.s_ack;
        others_req = |(bus.m_cyc & ~grant_q);
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] wdog_q;

    assign wdog_fire = own_cyc && own_stb && !bus.s_ack && (wdog_q == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
        end else if (!owning || ack_seen || wdog_fire) begin
            wdog_q <= '0;
        end else if (own_stb && !bus.s_ack) begin
            wdog_q <= wdog_q + 16'd1;
        end
    end
`else
    assign wdog_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q    <= OWN;
                        grant_q    <= pick_gnt;
                        hold_cnt_q <= '0;
                    end
                end
                OWN: begin
                    if (!own_cyc) begin
                        state_q  <= IDLE;
                        grant_q  <= '0;
                        rr_ptr_q <= next_ptr;
                    end else if (wdog_fire) begin
                        state_q  <= YIELD;
                        grant_q  <= '0;
                        rr_ptr_q <= next_ptr;
                    end else if (ack_seen) begin
                        if (hold_cnt_q < 8'(MAX_HOLD)) hold_cnt_q <= hold_cnt_q + 8'd1;
                        // >= so an owner whose count already saturated while
                        // alone still yields on its next ack once someone waits
                        if (hold_cnt_q >= 8'(MAX_HOLD - 1) && others_req) begin
                            state_q  <= YIELD;
                            grant_q  <= '0;
                            rr_ptr_q <= next_ptr;
                        end
                    end
                end
                YIELD: state_q <= IDLE;
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    // Slave side is a pure mux of the owner; gated by state so that an
    // asynchronous reset drops s_cyc immediately.
    always_comb begin
        bus.s_cyc   = own_cyc;
        bus.s_stb   = own_stb;
        bus.s_we    = 1'b0;
        bus.s_adr   = '0;
        bus.s_dat_w = '0;
        bus.s_sel   = '0;
        if (owning) begin
            bus.s_we    = bus.m_we[owner];
            bus.s_adr   = bus.m_adr[owner*ADR_W +: ADR_W];
            bus.s_dat_w = bus.m_dat_w[owner*DAT_W +: DAT_W];
            bus.s_sel   = bus.m_sel[owner*SEL_W +: SEL_W];
        end
        bus.m_ack   = grant_q & {NUM_MASTERS{bus.s_ack}};
        bus.m_err   = wdog_fire ? grant_q : '0;
        bus.m_dat_r = bus.s_dat_r;
        bus.grant   = grant_q;
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: a directed vector table, hand-written
// multi-cycle sequences (preemption, lone requester, mid-transfer reset) and a
// randomized phase, all compared every cycle against a behavioural model.
module tb_wb_rr_arbiter;
    import wb_arb_pkg::*;

    localparam int unsigned N        = 3;
    localparam int unsigned AW       = 32;
    localparam int unsigned DW       = 32;
    localparam int unsigned SW       = DW / 8;
    localparam int unsigned MAX_HOLD = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_arb_if #(.NUM_MASTERS(N), .ADR_W(AW), .DAT_W(DW)) bus ();

    wb_rr_arbiter #(
        .NUM_MASTERS(N),
        .ADR_W      (AW),
        .DAT_W      (DW),
        .MAX_HOLD   (MAX_HOLD),
        .TIMEOUT    (64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: who owns the bus, whether a forced hand-over gap is
    // pending, where the next search starts, and acks collected this grant.
    int owner      = -1;
    bit gap        = 1'b0;
    int next_first = 0;
    int acks       = 0;

    logic [N-1:0]  cur_cyc, cur_stb, cur_we;
    logic          cur_ack;
    logic [AW-1:0] adr_arr[N];
    logic [DW-1:0] datw_arr[N];
    logic [SW-1:0] sel_arr[N];
    logic [DW-1:0] cur_dat_r;
    bit            fixed_adr = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner      = -1;
        gap        = 1'b0;
        next_first = 0;
        acks       = 0;
    endtask

    task automatic compare_model();
        logic [N-1:0] e_grant;
        logic [N-1:0] e_ack;
        e_grant = '0;
        e_ack   = '0;
        if (owner >= 0) begin
            e_grant[owner] = 1'b1;
            e_ack[owner]   = cur_ack;
        end
        chk("grant", 64'(bus.grant), 64'(e_grant));
        chk("m_ack", 64'(bus.m_ack), 64'(e_ack));
        chk("m_err", 64'(bus.m_err), 64'(0));
        chk("m_dat_r", 64'(bus.m_dat_r), 64'(cur_dat_r));
        chk("s_cyc", 64'(bus.s_cyc), (owner >= 0) ? 64'(cur_cyc[owner]) : 64'(0));
        chk("s_stb", 64'(bus.s_stb), (owner >= 0) ? 64'(cur_stb[owner]) : 64'(0));
        chk("s_we", 64'(bus.s_we), (owner >= 0) ? 64'(cur_we[owner]) : 64'(0));
        chk("s_adr", 64'(bus.s_adr), (owner >= 0) ? 64'(adr_arr[owner]) : 64'(0));
        chk("s_dat_w", 64'(bus.s_dat_w), (owner >= 0) ? 64'(datw_arr[owner]) : 64'(0));
        chk("s_sel", 64'(bus.s_sel), (owner >= 0) ? 64'(sel_arr[owner]) : 64'(0));
    endtask

    // Called just after a rising edge: drive one cycle of inputs, then check
    // at the falling edge. The slave only acks when the model expects a strobe.
    task automatic drive(input logic [N-1:0] cyc, input logic [N-1:0] stb, input logic ack_req);
        cur_cyc = cyc;
        cur_stb = stb;
        cur_we  = N'($urandom);
        for (int i = 0; i < N; i++) begin
            adr_arr[i]  = fixed_adr ? AW'(32'h100 * (i + 1)) : AW'($urandom);
            datw_arr[i] = DW'($urandom);
            sel_arr[i]  = SW'($urandom);
            bus.m_adr[i*AW +: AW]   = adr_arr[i];
            bus.m_dat_w[i*DW +: DW] = datw_arr[i];
            bus.m_sel[i*SW +: SW]   = sel_arr[i];
        end
        bus.m_cyc = cyc;
        bus.m_stb = stb;
        bus.m_we  = cur_we;
        cur_ack   = ack_req && (owner >= 0) && stb[owner];
        cur_dat_r = DW'($urandom);
        bus.s_ack   = cur_ack;
        bus.s_dat_r = cur_dat_r;
        @(negedge clk);
        compare_model();
    endtask

    // Apply the arbitration rules to the cycle just checked, then move on.
    task automatic advance();
        if (gap) begin
            gap = 1'b0;
        end else if (owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (cur_cyc[(next_first + k) % N]) begin
                    owner = (next_first + k) % N;
                    acks  = 0;
                    break;
                end
            end
        end else if (!cur_cyc[owner]) begin
            next_first = (owner + 1) % N;
            owner      = -1;
        end else if (cur_ack) begin
            acks++;
            if (acks >= MAX_HOLD && (cur_cyc & ~(N'(1) << owner)) != '0) begin
                next_first = (owner + 1) % N;
                owner      = -1;
                gap        = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.m_cyc = '1;
        bus.m_stb = '1;
        bus.s_ack = 1'b1;
        @(negedge clk);
        chk("rst_grant", 64'(bus.grant), 64'(0));
        chk("rst_s_cyc", 64'(bus.s_cyc), 64'(0));
        chk("rst_m_ack", 64'(bus.m_ack), 64'(0));
        chk("rst_s_adr", 64'(bus.s_adr), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        bus.m_cyc = '0;
        bus.m_stb = '0;
        bus.s_ack = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0]  cyc;
        logic [N-1:0]  stb;
        logic          ack;
        logic [N-1:0]  grant;
        logic          s_cyc;
        logic [N-1:0]  m_ack;
        logic [AW-1:0] adr;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int m0_acks, before_m1, gaps2, acks2;
        bit m1_done, seen2;
        logic [N-1:0] rc, rs;

        // Three simultaneous requesters, then a lone read of 0x100 acked late.
        tbl[0]  = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 32'h0};
        tbl[1]  = '{3'b111, 3'b111, 1'b0, 3'b000, 1'b0, 3'b000, 32'h0};
        tbl[2]  = '{3'b111, 3'b111, 1'b1, 3'b001, 1'b1, 3'b001, 32'h100};
        tbl[3]  = '{3'b110, 3'b110, 1'b0, 3'b001, 1'b0, 3'b000, 32'h100};
        tbl[4]  = '{3'b110, 3'b110, 1'b0, 3'b000, 1'b0, 3'b000, 32'h0};
        tbl[5]  = '{3'b110, 3'b110, 1'b1, 3'b010, 1'b1, 3'b010, 32'h200};
        tbl[6]  = '{3'b100, 3'b100, 1'b0, 3'b010, 1'b0, 3'b000, 32'h200};
        tbl[7]  = '{3'b100, 3'b100, 1'b0, 3'b000, 1'b0, 3'b000, 32'h0};
        tbl[8]  = '{3'b100, 3'b100, 1'b1, 3'b100, 1'b1, 3'b100, 32'h300};
        tbl[9]  = '{3'b000, 3'b000, 1'b0, 3'b100, 1'b0, 3'b000, 32'h300};
        tbl[10] = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 32'h0};
        tbl[11] = '{3'b001, 3'b001, 1'b0, 3'b000, 1'b0, 3'b000, 32'h0};
        tbl[12] = '{3'b001, 3'b001, 1'b0, 3'b001, 1'b1, 3'b000, 32'h100};
        tbl[13] = '{3'b001, 3'b001, 1'b0, 3'b001, 1'b1, 3'b000, 32'h100};
        tbl[14] = '{3'b001, 3'b001, 1'b1, 3'b001, 1'b1, 3'b001, 32'h100};
        tbl[15] = '{3'b000, 3'b000, 1'b0, 3'b001, 1'b0, 3'b000, 32'h100};
        tbl[16] = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 32'h0};

        bus.m_cyc = '0; bus.m_stb = '0; bus.m_we = '0;
        bus.m_adr = '0; bus.m_dat_w = '0; bus.m_sel = '0;
        bus.s_ack = 1'b0; bus.s_dat_r = '0;
        @(posedge clk);
        #1;
        do_reset();

        fixed_adr = 1'b1;
        for (int v = 0; v < 17; v++) begin
            drive(tbl[v].cyc, tbl[v].stb, tbl[v].ack);
            chk($sformatf("tbl%0d_grant", v), 64'(bus.grant), 64'(tbl[v].grant));
            chk($sformatf("tbl%0d_s_cyc", v), 64'(bus.s_cyc), 64'(tbl[v].s_cyc));
            chk($sformatf("tbl%0d_m_ack", v), 64'(bus.m_ack), 64'(tbl[v].m_ack));
            chk($sformatf("tbl%0d_s_adr", v), 64'(bus.s_adr), 64'(tbl[v].adr));
            advance();
        end
        fixed_adr = 1'b0;

        // Master 0 streams 40 acks while master 1 waits for a single transfer.
        do_reset();
        m0_acks = 0; before_m1 = -1; m1_done = 1'b0;
        for (int c = 0; c < 200 && m0_acks < 40; c++) begin
            rc = {1'b0, !m1_done, 1'b1};
            drive(rc, rc, 1'b1);
            if (bus.m_ack[1]) begin
                if (before_m1 < 0) before_m1 = m0_acks;
                m1_done = 1'b1;
            end
            if (bus.m_ack[0]) m0_acks++;
            advance();
        end
        drive('0, '0, 1'b0);
        advance();
        chk("preempt_after_acks", 64'(before_m1), 64'(MAX_HOLD));
        chk("m0_total_acks", 64'(m0_acks), 64'(40));

        // Lone master 2: 100 acks without losing the grant.
        do_reset();
        gaps2 = 0; acks2 = 0; seen2 = 1'b0;
        for (int c = 0; c < 300 && acks2 < 100; c++) begin
            drive(3'b100, 3'b100, 1'b1);
            if (bus.grant == 3'b100) seen2 = 1'b1;
            else if (seen2) gaps2++;
            if (bus.m_ack[2]) acks2++;
            advance();
        end
        chk("lone_grant_gaps", 64'(gaps2), 64'(0));
        chk("lone_acks", 64'(acks2), 64'(100));
        // A competitor arriving after saturation still gets the bus.
        for (int c = 0; c < 6; c++) begin
            drive(3'b101, 3'b101, 1'b1);
            advance();
        end
        drive('0, '0, 1'b0);
        advance();

        // Reset while master 1 owns the bus mid-transfer.
        do_reset();
        drive(3'b010, 3'b010, 1'b0);
        advance();
        drive(3'b010, 3'b010, 1'b0);
        advance();
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_s_cyc", 64'(bus.s_cyc), 64'(0));
        chk("async_rst_grant", 64'(bus.grant), 64'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(3'b011, 3'b011, 1'b0);
        advance();
        drive(3'b011, 3'b011, 1'b0);
        chk("post_rst_grant", 64'(bus.grant), 64'(3'b001));
        advance();
        drive('0, '0, 1'b0);
        advance();

        // Randomized traffic against the model.
        rc = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rc[i]) begin
                    if ($urandom_range(0, 29) == 0) rc[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    rc[i] = 1'b1;
                end
                rs[i] = rc[i] && ($urandom_range(0, 3) != 0);
            end
            drive(rc, rs, $urandom_range(0, 2) != 0);
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone (classic, non-pipelined) arbiter that shares one slave port (the RAM) between NUM_MASTERS requesters, e.g. instruction fetch, data port and a future DMA.
- Replaces the fixed-priority instruction/data arbitration in front of ram_wb.
- Guarantees fairness, with a bounded hold time per grant.

Parameters:
- NUM_MASTERS, 3, number of requesting masters (2..8).
- ADR_W, 32, address width.
- DAT_W, 32, data width; SEL_W = DAT_W/8.
- MAX_HOLD, 16, acks a master may collect in one grant while another master is waiting (1..255).
- TIMEOUT, 64, cycles without ack before an error is returned (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- m_cyc  in  NUM_MASTERS  per-master cyc
- m_stb  in  NUM_MASTERS  per-master stb
- m_we  in  NUM_MASTERS  per-master we
- m_adr  in  NUM_MASTERS*ADR_W  per-master address (master i at bits [i*ADR_W +: ADR_W])
- m_dat_w  in  NUM_MASTERS*DAT_W  per-master write data
- m_sel  in  NUM_MASTERS*SEL_W  per-master byte selects
- m_ack  out  NUM_MASTERS  per-master ack
- m_err  out  NUM_MASTERS  per-master error (constant 0 without the optional feature)
- m_dat_r  out  DAT_W  read data broadcast to all masters
- s_cyc, s_stb, s_we  out  1  slave controls
- s_adr  out  ADR_W  slave address
- s_dat_w  out  DAT_W  slave write data
- s_sel  out  SEL_W  slave byte selects
- s_ack  in  1  slave ack
- s_dat_r  in  DAT_W  slave read data
- grant  out  NUM_MASTERS  one-hot current owner (debug/visibility)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, grant=0, rr_ptr=0, hold_cnt=0.
  - s_cyc, s_stb, s_we, m_ack, m_err all 0.
  - s_adr, s_dat_w, s_sel all 0.
- States:
  - IDLE: no owner.
  - OWN: grant is one-hot.
  - YIELD: one cycle with s_cyc=0, used for forced hand-over.
- IDLE -> OWN:
  - Request vector is m_cyc.
  - Picker searches circularly starting at rr_ptr; the first asserted bit wins.
  - Grant is registered: a master raising cyc at edge N sees s_cyc/s_stb driven from edge N+1.
  - Minimum request-to-ack latency is 1 cycle plus slave latency.
- OWN, datapath:
  - All s_* signals are a combinational mux of the owner's signals.
  - s_cyc = m_cyc[owner]; s_stb = m_stb[owner].
  - m_ack[owner] = s_ack; m_ack of every non-owner is 0.
- OWN -> IDLE: owner drops m_cyc.
  - rr_ptr <= owner+1, wrapping to 0 after NUM_MASTERS-1.
  - A new grant may be issued on the next edge; the minimum bus turnaround is 1 cycle.
- hold_cnt:
  - Increments on each s_ack while owning.
  - Clears on every new grant.
  - Saturates at MAX_HOLD.
- OWN -> YIELD:
  - Condition: an s_ack occurs with hold_cnt == MAX_HOLD-1 and any other m_cyc is high.
  - After that ack, s_cyc/s_stb drop for one cycle and rr_ptr <= owner+1.
  - The preempted master keeps cyc high and stalls; it is re-arbitrated normally.
- YIELD -> IDLE: unconditional after 1 cycle.
- A transfer is never cut mid-cycle. Preemption happens only on an ack boundary.
- Simultaneous release and request: the owner drops cyc in the same cycle another master raises it. Go to IDLE first; the grant is issued one cycle later.
- Single requester: never preempted, because the MAX_HOLD check requires another requester.
- A master dropping cyc while not granted has no effect.
- An owner dropping stb but keeping cyc keeps the grant (read-modify-write lock).
- Mid-operation reset aborts the cycle immediately. The slave sees s_cyc=0 asynchronously.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro:
  - A watchdog counts cycles in which s_stb=1 and s_ack=0.
  - On reaching TIMEOUT, pulse m_err[owner] for 1 cycle, force YIELD, and set rr_ptr past the owner.
  - The counter clears on each ack and on each new grant.
- Without the macro: no counter; m_err is tied to 0; TIMEOUT is ignored.

Decomposition:
- Package wb_arb_pkg:
  - State enum arb_state_t {IDLE, OWN, YIELD}.
  - Default width constants.
  - Function onehot_to_idx.
- Sub-module rr_priority_picker:
  - Combinational.
  - Inputs: req[NUM_MASTERS], ptr.
  - Outputs: one-hot gnt, valid.
  - Implemented by rotate, priority-encode, rotate back.
- The top holds the FSM, counters and muxes.

Test Plan:
- Single master 0 reads addr 0x100, slave acks after 2 cycles -> s_cyc rises 1 cycle after m_cyc[0]; m_ack[0] pulses once; m_dat_r equals slave data; grant=3'b001.
- Masters 0, 1 and 2 raise cyc in the same cycle after reset, each doing 1 transfer then dropping -> grant order 0, 1, 2 with 1 idle cycle between owners.
- Master 0 holds cyc for 40 back-to-back acks while master 1 waits, MAX_HOLD=16 -> after the 16th ack, YIELD for 1 cycle; master 1 is served; master 0 resumes; no ack goes to a non-owner.
- Master 2 holds cyc with no competitor for 100 acks -> never preempted; hold_cnt saturates.
- rst pulled low mid-transfer while master 1 owns the bus -> s_cyc=0 and grant=0 immediately; after release, arbitration restarts at master 0.
- With WB_ARB_TIMEOUT_EN, TIMEOUT=64, slave never acks master 0 -> m_err[0] pulses exactly at cycle 64 of stb; the grant passes to waiting master 1.
